// File: rtl/bus_slave.sv
// Responder on the shared open-drain serial bus: decodes the slave ID in the address,
// acks, then takes a write byte or fetches a local read byte and shifts it back out.
module bus_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDRS_WIDTH = 15,
    parameter int ID_WIDTH    = 3,
    parameter int SLAVE_ID    = 5,
    parameter int TIMEOUT_LEN = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    inout  wire                             b_BUS,
    input  logic                            b_RW,
    input  logic                            b_bus_utilizing,
    output logic [ADDRS_WIDTH-ID_WIDTH-1:0] s_address,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    output logic                            s_write,
    output logic                            s_read,
    input  logic [DATA_WIDTH-1:0]           s_rdata,
    input  logic                            s_rvalid,
    output logic                            s_busy
);

    localparam int LOC_W = ADDRS_WIDTH - ID_WIDTH;
    localparam int MAX_W = (ADDRS_WIDTH > DATA_WIDTH) ? ADDRS_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int SH_W  = MAX_W - 1;

    localparam logic [CNT_W-1:0]       ADDR_LAST = CNT_W'(ADDRS_WIDTH - 1);
    localparam logic [CNT_W-1:0]       ADDR_GAP  = CNT_W'(ADDRS_WIDTH);
    localparam logic [CNT_W-1:0]       DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TIMEOUT_LEN-1:0] TO_MAX    = {TIMEOUT_LEN{1'b1}};
    localparam logic [ID_WIDTH-1:0]    ID_MATCH  = ID_WIDTH'(SLAVE_ID);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK0, ACK1, W_WAIT, W_DATA, W_ACK0, W_ACK1,
        R_REQ, R_WAIT, T_START, T_SYNC, T_DATA, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SH_W-1:0]        sh_q, sh_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [TIMEOUT_LEN-1:0] to_q, to_d;
    logic [LOC_W-1:0]       s_address_q, s_address_d;
    logic [DATA_WIDTH-1:0]  s_wdata_q, s_wdata_d;
    logic                   s_write_q, s_write_d;
    logic                   s_read_q, s_read_d;
    logic                   s_busy_q, s_busy_d;

    logic                   bus_in;
    logic                   drive_low;
    logic [ADDRS_WIDTH-1:0] addr_full;
    logic [DATA_WIDTH-1:0]  wr_full;

    // Drive decoded straight from the state register so a reset edge releases the line at once.
    assign b_BUS     = drive_low ? 1'b0 : 1'bz;
    assign bus_in    = b_BUS;
    assign addr_full = {sh_q[ADDRS_WIDTH-2:0], bus_in};
    assign wr_full   = {sh_q[DATA_WIDTH-2:0], bus_in};

    assign s_address = s_address_q;
    assign s_wdata   = s_wdata_q;
    assign s_write   = s_write_q;
    assign s_read    = s_read_q;
    assign s_busy    = s_busy_q;

    always_comb begin
        drive_low = 1'b0;
        case (state_q)
            ACK0, ACK1, W_ACK0, T_START: drive_low = 1'b1;
            T_DATA:                      drive_low = ~tx_q[DATA_WIDTH-1];
            default:                     drive_low = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        to_d        = to_q;
        s_address_d = s_address_q;
        s_wdata_d   = s_wdata_q;
        s_write_d   = 1'b0;
        s_read_d    = 1'b0;
        s_busy_d    = s_busy_q;

        if (state_q != IDLE && !b_bus_utilizing) begin
            state_d  = IDLE;
            s_busy_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (b_bus_utilizing && !bus_in) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                    end
                end
                ADDR: begin
                    // Count ADDRS_WIDTH doubles as the one-clock gap before the ack.
                    if (cnt_q == ADDR_GAP) begin
                        state_d = ACK0;
                    end else begin
                        sh_d  = {sh_q[SH_W-2:0], bus_in};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == ADDR_LAST) begin
                            if (addr_full[ADDRS_WIDTH-1 -: ID_WIDTH] == ID_MATCH) begin
                                s_address_d = addr_full[LOC_W-1:0];
                                s_busy_d    = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                ACK0: state_d = ACK1;
                ACK1: begin
                    if (b_RW) begin
                        state_d = W_WAIT;
                    end else begin
                        state_d  = R_REQ;
                        s_read_d = 1'b1;
                    end
                end
                W_WAIT: begin
                    if (!bus_in) begin
                        state_d = W_DATA;
                        cnt_d   = '0;
                    end
                end
                W_DATA: begin
                    sh_d  = {sh_q[SH_W-2:0], bus_in};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        s_wdata_d = wr_full;
                        s_write_d = 1'b1;
                        state_d   = W_ACK0;
                    end
                end
                W_ACK0: state_d = W_ACK1;
                W_ACK1: state_d = DONE;
                R_REQ: begin
                    state_d = R_WAIT;
                    to_d    = '0;
                end
                R_WAIT: begin
                    if (s_rvalid) begin
                        tx_d    = s_rdata;
                        state_d = T_START;
                    end else if (to_q == TO_MAX) begin
                        state_d = DONE;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                T_START: state_d = T_SYNC;
                T_SYNC: begin
                    state_d = T_DATA;
                    cnt_d   = '0;
                end
                T_DATA: begin
                    tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            to_q        <= '0;
            s_address_q <= '0;
            s_wdata_q   <= '0;
            s_write_q   <= 1'b0;
            s_read_q    <= 1'b0;
            s_busy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            to_q        <= to_d;
            s_address_q <= s_address_d;
            s_wdata_q   <= s_wdata_d;
            s_write_q   <= s_write_d;
            s_read_q    <= s_read_d;
            s_busy_q    <= s_busy_d;
        end
    end

endmodule

// File: tb/tb_bus_slave.sv
// Bench acting as the bus master and local memory; each frame's expected slave behaviour is
// planned slot by slot from the protocol timeline and compared as per-frame bit masks.
module tb_bus_slave;

    localparam int DW   = 8;
    localparam int AW   = 15;
    localparam int IW   = 3;
    localparam int SID  = 5;
    localparam int TL   = 6;
    localparam int LW   = AW - IW;
    localparam int MAXS = 192;

    logic          clk = 1'b0;
    logic          rst;
    wire           bus;
    logic          m_low;
    logic          b_rw;
    logic          util;
    logic [LW-1:0] s_address;
    logic [DW-1:0] s_wdata;
    logic          s_write;
    logic          s_read;
    logic [DW-1:0] s_rdata;
    logic          s_rvalid;
    logic          s_busy;

    assign bus = m_low ? 1'b0 : 1'bz;
    pullup (bus);

    always #5 clk = ~clk;

    bus_slave #(
        .DATA_WIDTH (DW),
        .ADDRS_WIDTH(AW),
        .ID_WIDTH   (IW),
        .SLAVE_ID   (SID),
        .TIMEOUT_LEN(TL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .b_BUS          (bus),
        .b_RW           (b_rw),
        .b_bus_utilizing(util),
        .s_address      (s_address),
        .s_wdata        (s_wdata),
        .s_write        (s_write),
        .s_read         (s_read),
        .s_rdata        (s_rdata),
        .s_rvalid       (s_rvalid),
        .s_busy         (s_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [LW-1:0] hold_addr  = '0;
    logic [DW-1:0] hold_wdata = '0;

    task automatic check_eq(input string tag, input logic [MAXS-1:0] obs, input logic [MAXS-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // abort_at: slot in which the master drops b_bus_utilizing (0 = natural end).
    // rst_at: slot in which rst is held high (0 = none). rdly > 64 means s_rvalid never comes.
    task automatic run_frame(input string name, input logic rw, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                             input int gap, input int rdly, input int abort_at,
                             input int rst_at, input int hold);
        logic          match, served;
        int            e_slot, a_slot, t_slot, n_slots, wr_slot, bi;
        logic [MAXS-1:0] exp_drv, exp_wr, exp_rd, exp_busy;
        logic [MAXS-1:0] obs_drv, obs_wr, obs_rd, obs_busy;
        logic [DW-1:0] obs_wdata, end_wdata;
        logic [LW-1:0] obs_addr, end_addr;

        match   = (addr[AW-1 -: IW] == IW'(SID));
        served  = (rdly <= 64);
        wr_slot = 28 + gap;
        if (!match)      e_slot = 16 + hold;
        else if (rw)     e_slot = 30 + gap + hold;
        else if (served) e_slot = 30 + rdly + hold;
        else             e_slot = 84 + hold;
        a_slot = e_slot;
        if (abort_at > 0 && abort_at < a_slot) a_slot = abort_at;
        t_slot = a_slot;
        if (rst_at > 0) begin
            t_slot = rst_at;
            a_slot = rst_at + 1;
        end
        n_slots = a_slot + 3;

        exp_drv = '0; exp_wr = '0; exp_rd = '0; exp_busy = '0;
        obs_drv = '0; obs_wr = '0; obs_rd = '0; obs_busy = '0;
        obs_wdata = '0; obs_addr = '0; end_wdata = '0; end_addr = '0;

        for (int s = 0; s < n_slots; s++) begin
            if (match && s <= t_slot) begin
                exp_busy[s] = (s >= 16);
                exp_rd[s]   = !rw && (s == 19);
                exp_wr[s]   = rw && (s == wr_slot);
                exp_drv[s]  = (s == 17) || (s == 18) || (rw && s == wr_slot) ||
                              (!rw && served && s == 20 + rdly);
                bi = s - 22 - rdly;
                if (!rw && served && bi >= 0 && bi < DW) exp_drv[s] = !rdata[DW-1-bi];
            end

            #1;
            util  = (s < a_slot);
            rst   = (rst_at > 0) && (s == rst_at);
            b_rw  = rw;
            m_low = 1'b0;
            if (s < a_slot) begin
                if (s == 0)                                m_low = 1'b1;
                else if (s <= AW)                          m_low = !addr[AW-s];
                else if (rw && s == 19 + gap)              m_low = 1'b1;
                else if (rw && s >= 20 + gap && s <= 27 + gap) m_low = !wdata[DW-1-(s-20-gap)];
            end
            s_rvalid = match && !rw && (s == 19 + rdly);
            s_rdata  = s_rvalid ? rdata : DW'($urandom);

            @(negedge clk);
            obs_drv[s]  = !m_low && (bus === 1'b0);
            obs_wr[s]   = s_write;
            obs_rd[s]   = s_read;
            obs_busy[s] = s_busy;
            if (s == wr_slot) obs_wdata = s_wdata;
            if (s == 16)      obs_addr  = s_address;
            if (s == n_slots - 1) begin
                end_addr  = s_address;
                end_wdata = s_wdata;
            end
            @(posedge clk);
        end
        rst = 1'b0;

        $display("frame %s: rw=%0b addr=%0d id=%0d match=%0b last_valid_slot=%0d",
                 name, rw, addr, addr[AW-1 -: IW], match, t_slot);
        check_eq({name, ".drive"}, obs_drv, exp_drv);
        check_eq({name, ".s_write"}, obs_wr, exp_wr);
        check_eq({name, ".s_read"}, obs_rd, exp_rd);
        check_eq({name, ".s_busy"}, obs_busy, exp_busy);
        if (match && t_slot >= 16)
            check_eq({name, ".s_address"}, MAXS'(obs_addr), MAXS'(addr[LW-1:0]));
        if (match && rw && wr_slot <= t_slot)
            check_eq({name, ".s_wdata"}, MAXS'(obs_wdata), MAXS'(wdata));

        if (rst_at > 0) begin
            hold_addr  = '0;
            hold_wdata = '0;
        end else begin
            if (match && t_slot >= 16)               hold_addr  = addr[LW-1:0];
            if (match && rw && wr_slot <= t_slot)    hold_wdata = wdata;
        end
        check_eq({name, ".addr_hold"}, MAXS'(end_addr), MAXS'(hold_addr));
        check_eq({name, ".wdata_hold"}, MAXS'(end_wdata), MAXS'(hold_wdata));
    endtask

    initial begin
        logic          rw;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        int            r, rdly, abort_at;

        rst = 1'b1; util = 1'b0; m_low = 1'b0; b_rw = 1'b0;
        s_rvalid = 1'b0; s_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset.s_busy", MAXS'(s_busy), '0);
        check_eq("reset.s_write", MAXS'(s_write), '0);
        check_eq("reset.s_read", MAXS'(s_read), '0);
        check_eq("reset.s_address", MAXS'(s_address), '0);
        check_eq("reset.s_wdata", MAXS'(s_wdata), '0);
        check_eq("reset.bus_released", MAXS'(bus === 1'b1), MAXS'(1));
        @(posedge clk);

        run_frame("t1_write",    1'b1, 15'd21846, 8'd204, 8'd0,   0, 1000, 0,  0, 2);
        run_frame("t2_read",     1'b0, 15'd21845, 8'd0,   8'd203, 0, 3,    0,  0, 2);
        run_frame("t3_other_id", 1'b1, 15'h2ABC,  8'd77,  8'd0,   0, 1000, 0,  0, 5);
        run_frame("t4_abort",    1'b0, 15'd21845, 8'd0,   8'd55,  0, 2,    8,  0, 2);
        run_frame("t5_timeout",  1'b0, 15'h5123,  8'd0,   8'd99,  0, 1000, 0,  0, 3);
        run_frame("t6_rst",      1'b0, 15'h5777,  8'd0,   8'hA5,  0, 2,    0,  28, 0);
        run_frame("t6_after",    1'b1, 15'h5F0F,  8'h3C,  8'd0,   1, 1000, 0,  0, 1);

        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            id = IW'(SID);
            if ($urandom_range(0, 9) < 2) begin
                id = IW'($urandom);
                if (id == IW'(SID)) id = id + 1'b1;
            end
            addr = {id, LW'($urandom)};
            r = $urandom_range(0, 9);
            if (r == 0)      rdly = 1000;
            else if (r == 1) rdly = $urandom_range(62, 66);
            else             rdly = $urandom_range(1, 6);
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : 0;
            run_frame($sformatf("rnd%0d", i), rw, addr, DW'($urandom), DW'($urandom),
                      $urandom_range(0, 3), rdly, abort_at, 0, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
